// File: rtl/dm_lsu.sv
// Load/store unit in front of a 32-word data memory.
// Sub-word stores are done as a read-modify-write. Loads return the lane, sign- or zero-extended.
module dm_lsu #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [4:0]        addressDM,
  output logic              we,
  output logic [31:0]       wd,
  input  logic [31:0]       rd
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_e              state_q, state_d;
  logic                st_q, st_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [31:0]         old_q, old_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                req_err;
  logic [7:0]          rd_byte [4];
  logic [7:0]          sel_byte;
  logic [15:0]         sel_half;
  logic [31:0]         load_fmt;
  logic [3:0]          lane_hit;
  logic [31:0]         merged;

  // Misalignment and illegal size are rejected before any memory access
  assign req_err = (req_size == SZ_ILL)
                 | ((req_size == SZ_HALF) & req_addr[0])
                 | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign rd_byte[gi]  = rd[8*gi +: 8];
      assign lane_hit[gi] = (size_q == SZ_BYTE) ? (addr_q[1:0] == LANE)
                                                : (addr_q[1] == LANE[1]);
      // Byte stores replicate the low byte into the hit lane; halves use the matching half byte
      assign merged[8*gi +: 8] = !lane_hit[gi]        ? old_q[8*gi +: 8] :
                                 (size_q == SZ_BYTE)  ? wdata_q[7:0]     :
                                                        wdata_q[8*(gi%2) +: 8];
    end
  endgenerate

  assign sel_byte = rd_byte[addr_q[1:0]];
  assign sel_half = addr_q[1] ? rd[31:16] : rd[15:0];

  always_comb begin
    load_fmt = rd;
    case (size_q)
      SZ_BYTE: load_fmt = {{24{~uns_q & sel_byte[7]}}, sel_byte};
      SZ_HALF: load_fmt = {{16{~uns_q & sel_half[15]}}, sel_half};
      default: load_fmt = rd;
    endcase
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    old_d   = old_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          st_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = req_err;
          if (req_err) begin
            rdata_d = 32'd0;
            state_d = RESP;
          end else if (!req_we) begin
            state_d = LOAD;
          end else if (req_size == SZ_WORD) begin
            state_d = WRITE;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LOAD: begin
        rdata_d = load_fmt;
        state_d = RESP;
      end
      RMW_RD: begin
        old_d   = rd;
        state_d = WRITE;
      end
      WRITE: begin
        rdata_d = 32'd0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      old_q   <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
    end
  end

  // The store/load flag only steers the branch out of IDLE; outputs depend on state alone
  logic unused_st;
  assign unused_st = st_q;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) & err_q;
  assign resp_rdata = rdata_q;
  assign we         = (state_q == WRITE);
  assign addressDM  = addr_q[2 +: 5];
  assign wd         = (size_q == SZ_WORD) ? wdata_q : merged;

endmodule

// File: tb/tb_dm_lsu.sv
// Scoreboard bench for dm_lsu: directed requests push expectations, a negedge monitor checks responses.
module tb_dm_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [6:0]  req_addr = 7'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [4:0]  addressDM;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;

  dm_lsu #(.ADDR_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .addressDM(addressDM), .we(we), .wd(wd), .rd(rd)
  );

  always #5 clk = ~clk;

  // Data memory model
  logic [31:0] mem [32];
  logic        mem_clr = 1'b1;
  assign rd = mem[addressDM];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
    end else if (we) begin
      mem[addressDM] <= wd;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    int          we_n;
    logic [4:0]  addr;
    logic [31:0] wd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  int   we_seen = 0;
  logic prev_rv = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      we_seen = 0;
      prev_rv = 1'b0;
    end else begin
      if (we) begin
        if (sb.size() == 0) chk("we_unexpected", 32'(we), 32'd0);
        else begin
          chk("we_addr", 32'(addressDM), 32'(sb[0].addr));
          chk("we_wd", wd, sb[0].wd);
        end
        we_seen++;
      end
      if (resp_valid) begin
        if (sb.size() == 0) chk("resp_unexpected", 32'(resp_valid), 32'd0);
        else begin
          e = sb.pop_front();
          chk("rdata", resp_rdata, e.rdata);
          chk("err", 32'(resp_err), 32'(e.err));
          chk("latency_cycle", 32'(cyc), 32'(e.due));
          chk("we_cycles", 32'(we_seen), 32'(e.we_n));
          chk("resp_pulse", 32'(prev_rv), 32'd0);
          $display("resp: rdata=%h err=%0d cycle=%0d", resp_rdata, resp_err, cyc);
        end
        we_seen = 0;
      end
      prev_rv = resp_valid;
    end
  end

  task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                       input logic [6:0] a, input logic [31:0] d);
    req_we = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
  endtask

  // Called at a negedge; returns once accepted at the next posedge + half cycle
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [6:0] a, input logic [31:0] d,
                       input logic [31:0] x_rdata, input logic x_err,
                       input int x_we_n, input logic [31:0] x_wd, input int lat);
    exp_t e;
    int   tmo;
    drive(w, sz, u, a, d);
    req_valid = 1'b1;
    tmo = 0;
    while (!req_ready && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
    e.rdata = x_rdata; e.err = x_err; e.due = cyc + lat;
    e.we_n = x_we_n; e.addr = a[6:2]; e.wd = x_wd;
    sb.push_back(e);
    $display("req: we=%0d size=%0d uns=%0d addr=%h wdata=%h", w, sz, u, a, d);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int tmo;
    tmo = 0;
    while (sb.size() != 0 && tmo < 30) begin
      @(negedge clk);
      tmo++;
    end
    if (sb.size() != 0) begin
      chk("resp_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  logic pat [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [6:0]  b2b_addr [3] = '{7'h00, 7'h04, 7'h08};
  logic [31:0] b2b_data [3] = '{32'hAAAAAAAA, 32'hBBBB5ABB, 32'hCCCCCCCC};

  initial begin
    exp_t e;
    int   k;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_addressDM", 32'(addressDM), 32'd0);
    chk("rst_wd", wd, 32'd0);
    rst_n = 1'b1;
    mem_clr = 1'b0;
    @(negedge clk);

    //     we    size   uns   addr    wdata          rdata          err  we_n wd             lat
    issue(1'b1, 2'b10, 1'b0, 7'h00, 32'hAAAAAAAA, 32'h00000000, 1'b0, 1, 32'hAAAAAAAA, 2); drain();
    issue(1'b0, 2'b10, 1'b0, 7'h00, 32'h0,        32'hAAAAAAAA, 1'b0, 0, 32'h0,        2); drain();
    issue(1'b1, 2'b10, 1'b0, 7'h04, 32'hBBBBBBBB, 32'h00000000, 1'b0, 1, 32'hBBBBBBBB, 2); drain();
    issue(1'b1, 2'b00, 1'b0, 7'h05, 32'hFFFFFF5A, 32'h00000000, 1'b0, 1, 32'hBBBB5ABB, 3); drain();
    issue(1'b0, 2'b10, 1'b0, 7'h04, 32'h0,        32'hBBBB5ABB, 1'b0, 0, 32'h0,        2); drain();
    issue(1'b0, 2'b00, 1'b0, 7'h07, 32'h0,        32'hFFFFFFBB, 1'b0, 0, 32'h0,        2); drain();
    issue(1'b0, 2'b00, 1'b1, 7'h07, 32'h0,        32'h000000BB, 1'b0, 0, 32'h0,        2); drain();
    issue(1'b0, 2'b01, 1'b0, 7'h06, 32'h0,        32'hFFFFBBBB, 1'b0, 0, 32'h0,        2); drain();
    issue(1'b0, 2'b01, 1'b0, 7'h04, 32'h0,        32'h00005ABB, 1'b0, 0, 32'h0,        2); drain();
    issue(1'b1, 2'b10, 1'b0, 7'h08, 32'hCCCCCCCC, 32'h00000000, 1'b0, 1, 32'hCCCCCCCC, 2); drain();
    issue(1'b1, 2'b10, 1'b0, 7'h0A, 32'h11111111, 32'h00000000, 1'b1, 0, 32'h0,        1); drain();
    issue(1'b0, 2'b10, 1'b0, 7'h08, 32'h0,        32'hCCCCCCCC, 1'b0, 0, 32'h0,        2); drain();
    issue(1'b0, 2'b01, 1'b0, 7'h03, 32'h0,        32'h00000000, 1'b1, 0, 32'h0,        1); drain();
    issue(1'b0, 2'b11, 1'b0, 7'h00, 32'h0,        32'h00000000, 1'b1, 0, 32'h0,        1); drain();
    issue(1'b1, 2'b01, 1'b0, 7'h0C, 32'hFFFF8001, 32'h00000000, 1'b0, 1, 32'h00008001, 3); drain();
    issue(1'b1, 2'b01, 1'b0, 7'h0E, 32'h0000ABCD, 32'h00000000, 1'b0, 1, 32'hABCD8001, 3); drain();
    issue(1'b0, 2'b10, 1'b0, 7'h0C, 32'h0,        32'hABCD8001, 1'b0, 0, 32'h0,        2); drain();
    issue(1'b0, 2'b00, 1'b1, 7'h0F, 32'h0,        32'h000000AB, 1'b0, 0, 32'h0,        2); drain();
    issue(1'b1, 2'b10, 1'b0, 7'h10, 32'h12345678, 32'h00000000, 1'b0, 1, 32'h12345678, 2); drain();

    // Half store to 0x10 aborted by reset while in RMW_RD
    drive(1'b1, 2'b01, 1'b0, 7'h10, 32'h0000BEEF);
    req_valid = 1'b1;
    chk("abort_ready_before", 32'(req_ready), 32'd1);
    $display("req: we=1 size=1 uns=0 addr=10 wdata=0000beef (reset during RMW_RD)");
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("abort_we", 32'(we), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_ready_async", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
      chk("abort_no_we", 32'(we), 32'd0);
    end
    issue(1'b0, 2'b10, 1'b0, 7'h10, 32'h0, 32'h12345678, 1'b0, 0, 32'h0, 2); drain();

    // Three back-to-back word loads with req_valid held high
    k = 0;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (k < 3) drive(1'b0, 2'b10, 1'b0, b2b_addr[k], 32'h0);
      else req_valid = 1'b0;
      chk("b2b_ready", 32'(req_ready), 32'(pat[i]));
      if (req_ready && k < 3) begin
        e.rdata = b2b_data[k]; e.err = 1'b0; e.due = cyc + 2;
        e.we_n = 0; e.addr = b2b_addr[k][6:2]; e.wd = 32'h0;
        sb.push_back(e);
        $display("req: we=0 size=2 uns=0 addr=%h wdata=00000000 (back-to-back)", b2b_addr[k]);
        k++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
